// File: rtl/ip_master_soc_ctrl_nslave_if.sv
// Bus bundle between the IPM bridge, the N-slave SoC controller and its AIP slave cores.
interface ip_master_soc_ctrl_nslave_if #(
  parameter int N_SLAVES   = 11,
  parameter int DATA_WIDTH = 32,
  parameter int CONF_WIDTH = 5
);
  logic                           i_en_s;
  logic [DATA_WIDTH-1:0]          i_data_in;
  logic [DATA_WIDTH-1:0]          o_data_out;
  logic                           i_write;
  logic                           i_read;
  logic                           i_start;
  logic [CONF_WIDTH-1:0]          i_conf_dbus;
  logic                           o_int_req;
  logic [N_SLAVES*DATA_WIDTH-1:0] o_dataInAIP_IP;
  logic [N_SLAVES*CONF_WIDTH-1:0] o_configAIP_IP;
  logic [N_SLAVES-1:0]            o_writeAIP_IP;
  logic [N_SLAVES-1:0]            o_readAIP_IP;
  logic [N_SLAVES-1:0]            o_start_IP;
  logic [N_SLAVES*DATA_WIDTH-1:0] i_dataOutAIP_IP;
  logic [N_SLAVES-1:0]            i_int_IP;

  modport master (
    input  i_en_s, i_data_in, i_write, i_read, i_start, i_conf_dbus,
    input  i_dataOutAIP_IP, i_int_IP,
    output o_data_out, o_int_req, o_dataInAIP_IP, o_configAIP_IP,
    output o_writeAIP_IP, o_readAIP_IP, o_start_IP
  );

  modport slave (
    output i_en_s, i_data_in, i_write, i_read, i_start, i_conf_dbus,
    output i_dataOutAIP_IP, i_int_IP,
    input  o_data_out, o_int_req, o_dataInAIP_IP, o_configAIP_IP,
    input  o_writeAIP_IP, o_readAIP_IP, o_start_IP
  );
endinterface

// File: rtl/ip_master_soc_ctrl_nslave.sv
// Master-side SoC controller: routes IPM accesses to one or all of N_SLAVES AIP cores,
// returns read data, and aggregates slave interrupts into pending/mask with one request line.
module ip_master_soc_ctrl_nslave #(
  parameter int N_SLAVES   = 11,
  parameter int DATA_WIDTH = 32,
  parameter int CONF_WIDTH = 5,
  parameter int SEL_WIDTH  = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst_a,
  ip_master_soc_ctrl_nslave_if.master   bus
);
  localparam int N  = N_SLAVES;
  localparam int DW = DATA_WIDTH;
  localparam int CW = CONF_WIDTH;

  localparam logic [CW-1:0] CODE_SEL    = {CW{1'b1}};
  localparam logic [CW-1:0] CODE_STATUS = {CW{1'b1}} - CW'(1);
  localparam logic [CW-1:0] CODE_MASK   = {CW{1'b1}} - CW'(2);
  localparam logic [CW-1:0] CODE_CLR    = {CW{1'b1}} - CW'(3);

  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 bcast_q, bcast_d;
  logic                 err_q, err_d;
  logic [N-1:0]         mask_q, mask_d;
  logic [N-1:0]         pending_q, pending_d;
  logic [N-1:0]         int_sync_q, int_prev_q;
  logic                 int_req_q, int_req_d;
  logic [DW-1:0]        data_out_q, data_out_d;
  logic [N*DW-1:0]      data_aip_q, data_aip_d;
  logic [N*CW-1:0]      conf_aip_q, conf_aip_d;
  logic [N-1:0]         write_q, write_d;
  logic [N-1:0]         read_q, read_d;
  logic [N-1:0]         start_q, start_d;

  logic                 reserved;
  logic                 fwd;
  logic [N-1:0]         target;
  logic [N-1:0]         clr;
  logic [DW-1:0]        rd_slice;
  logic [DW-1:0]        status_val;
  logic [DW-1:0]        sel_val;

  always_comb begin
    sel_d      = sel_q;
    bcast_d    = bcast_q;
    err_d      = err_q;
    mask_d     = mask_q;
    data_out_d = data_out_q;
    data_aip_d = data_aip_q;
    conf_aip_d = conf_aip_q;
    write_d    = '0;
    read_d     = '0;
    start_d    = '0;
    clr        = '0;
    target     = '0;
    rd_slice   = '0;

    reserved = (bus.i_conf_dbus[CW-1:2] == '1);
    // err_q blocks forwarding so an out-of-range select can never hit a slave.
    fwd      = bus.i_en_s && !reserved && !err_q;

    for (int s = 0; s < N; s++) begin
      target[s] = bcast_q || (sel_q == SEL_WIDTH'(s));
      if (sel_q == SEL_WIDTH'(s)) rd_slice = bus.i_dataOutAIP_IP[s*DW +: DW];
    end

    if (fwd && bus.i_write) write_d = target;
    if (fwd && bus.i_read)  read_d  = target;
    if (fwd && bus.i_start) start_d = target;

    for (int s = 0; s < N; s++) begin
      if (write_d[s]) data_aip_d[s*DW +: DW] = bus.i_data_in;
      if (write_d[s] || read_d[s]) conf_aip_d[s*CW +: CW] = bus.i_conf_dbus;
    end

    if (bus.i_en_s && bus.i_write) begin
      case (bus.i_conf_dbus)
        CODE_SEL: begin
          sel_d   = bus.i_data_in[SEL_WIDTH-1:0];
          bcast_d = bus.i_data_in[DW-1];
          err_d   = !bus.i_data_in[DW-1] &&
                    ({1'b0, bus.i_data_in[SEL_WIDTH-1:0]} >= (SEL_WIDTH+1)'(N_SLAVES));
        end
        CODE_MASK: mask_d = bus.i_data_in[N-1:0];
        CODE_CLR:  clr    = bus.i_data_in[N-1:0];
        default: ;
      endcase
    end

    // A new edge is OR-ed in after the clear so a coincident edge is never lost.
    pending_d = (pending_q & ~clr) | (int_sync_q & ~int_prev_q);
    int_req_d = |(pending_q & mask_q);

    status_val           = '0;
    status_val[N-1:0]    = pending_q;
    status_val[DW-1]     = err_q;
    sel_val              = '0;
    sel_val[SEL_WIDTH-1:0] = sel_q;
    sel_val[DW-1]        = bcast_q;

    if (bus.i_en_s) begin
      case (bus.i_conf_dbus)
        CODE_STATUS: data_out_d = status_val;
        CODE_MASK:   data_out_d = {{(DW-N){1'b0}}, mask_q};
        CODE_SEL:    data_out_d = sel_val;
        default:     data_out_d = rd_slice;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_a) begin
    if (!i_rst_a) begin
      sel_q      <= '0;
      bcast_q    <= 1'b0;
      err_q      <= 1'b0;
      mask_q     <= '0;
      pending_q  <= '0;
      int_sync_q <= '0;
      int_prev_q <= '0;
      int_req_q  <= 1'b0;
      data_out_q <= '0;
      data_aip_q <= '0;
      conf_aip_q <= '0;
      write_q    <= '0;
      read_q     <= '0;
      start_q    <= '0;
    end else begin
      sel_q      <= sel_d;
      bcast_q    <= bcast_d;
      err_q      <= err_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      int_sync_q <= bus.i_int_IP;
      int_prev_q <= int_sync_q;
      int_req_q  <= int_req_d;
      data_out_q <= data_out_d;
      data_aip_q <= data_aip_d;
      conf_aip_q <= conf_aip_d;
      write_q    <= write_d;
      read_q     <= read_d;
      start_q    <= start_d;
    end
  end

  assign bus.o_data_out     = data_out_q;
  assign bus.o_int_req      = int_req_q;
  assign bus.o_dataInAIP_IP = data_aip_q;
  assign bus.o_configAIP_IP = conf_aip_q;
  assign bus.o_writeAIP_IP  = write_q;
  assign bus.o_readAIP_IP   = read_q;
  assign bus.o_start_IP     = start_q;
endmodule

// File: tb/tb_ip_master_soc_ctrl_nslave.sv
// Directed bench for the N-slave SoC controller with N_SLAVES=11, 32-bit data, 5-bit config.
module tb_ip_master_soc_ctrl_nslave;
  localparam int N  = 11;
  localparam int DW = 32;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_a;

  ip_master_soc_ctrl_nslave_if #(.N_SLAVES(N), .DATA_WIDTH(DW), .CONF_WIDTH(CW)) bus ();

  ip_master_soc_ctrl_nslave #(
    .N_SLAVES(N), .DATA_WIDTH(DW), .CONF_WIDTH(CW), .SEL_WIDTH(5)
  ) dut (
    .i_clk   (clk),
    .i_rst_a (rst_a),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [N*DW-1:0] exp_data;
  logic [N*CW-1:0] exp_conf;

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [CW-1:0] code, input logic [DW-1:0] d);
    bus.i_conf_dbus = code;
    bus.i_data_in   = d;
    bus.i_write     = 1'b1;
    tick();
    bus.i_write     = 1'b0;
  endtask

  initial begin
    rst_a               = 1'b0;
    bus.i_en_s          = 1'b1;
    bus.i_data_in       = '0;
    bus.i_write         = 1'b0;
    bus.i_read          = 1'b0;
    bus.i_start         = 1'b0;
    bus.i_conf_dbus     = '0;
    bus.i_dataOutAIP_IP = '0;
    bus.i_int_IP        = '0;
    exp_data            = '0;
    exp_conf            = '0;

    tick();
    tick();
    chk("rst_data_out", bus.o_data_out, 0);
    chk("rst_int_req", bus.o_int_req, 0);
    chk("rst_write", bus.o_writeAIP_IP, 0);
    chk("rst_data_aip", bus.o_dataInAIP_IP, 0);
    chk("rst_conf_aip", bus.o_configAIP_IP, 0);
    rst_a = 1'b1;
    tick();

    // T1: select slave 3 and write
    cfg(5'h1F, 32'd3);
    bus.i_conf_dbus = 5'h1F;
    tick();
    chk("t1_sel_readback", bus.o_data_out, 32'd3);
    bus.i_conf_dbus = 5'h02;
    bus.i_data_in   = 32'hDEADBEEF;
    bus.i_write     = 1'b1;
    tick();
    bus.i_write     = 1'b0;
    exp_data[3*DW +: DW] = 32'hDEADBEEF;
    exp_conf[3*CW +: CW] = 5'h02;
    chk("t1_write_strobe", bus.o_writeAIP_IP, 11'h008);
    chk("t1_data_slices", bus.o_dataInAIP_IP, exp_data);
    chk("t1_conf_slices", bus.o_configAIP_IP, exp_conf);
    tick();
    chk("t1_write_one_cycle", bus.o_writeAIP_IP, 0);
    chk("t1_data_hold", bus.o_dataInAIP_IP, exp_data);

    // T2: broadcast start, then read slave 5
    cfg(5'h1F, 32'h8000_0000);
    bus.i_conf_dbus = 5'h03;
    bus.i_start     = 1'b1;
    tick();
    bus.i_start     = 1'b0;
    chk("t2_bcast_start", bus.o_start_IP, 11'h7FF);
    chk("t2_bcast_no_write", bus.o_writeAIP_IP, 0);
    tick();
    chk("t2_start_one_cycle", bus.o_start_IP, 0);
    bus.i_conf_dbus = 5'h1F;
    tick();
    chk("t2_sel_bcast_readback", bus.o_data_out, 32'h8000_0000);
    cfg(5'h1F, 32'd5);
    bus.i_dataOutAIP_IP[5*DW +: DW] = 32'h0000_1234;
    bus.i_conf_dbus = 5'h04;
    bus.i_read      = 1'b1;
    tick();
    bus.i_read      = 1'b0;
    exp_conf[5*CW +: CW] = 5'h04;
    chk("t2_read_strobe", bus.o_readAIP_IP, 11'h020);
    chk("t2_read_conf", bus.o_configAIP_IP, exp_conf);
    chk("t2_read_data", bus.o_data_out, 32'h0000_1234);
    chk("t2_data_untouched", bus.o_dataInAIP_IP, exp_data);

    // T3: out-of-range select
    cfg(5'h1F, 32'd12);
    bus.i_conf_dbus = 5'h02;
    bus.i_data_in   = 32'h5555_5555;
    bus.i_write     = 1'b1;
    bus.i_start     = 1'b1;
    tick();
    bus.i_write     = 1'b0;
    bus.i_start     = 1'b0;
    chk("t3_no_write", bus.o_writeAIP_IP, 0);
    chk("t3_no_start", bus.o_start_IP, 0);
    chk("t3_data_hold", bus.o_dataInAIP_IP, exp_data);
    bus.i_conf_dbus = 5'h04;
    bus.i_read      = 1'b1;
    tick();
    bus.i_read      = 1'b0;
    chk("t3_no_read", bus.o_readAIP_IP, 0);
    chk("t3_conf_hold", bus.o_configAIP_IP, exp_conf);
    chk("t3_oor_read_zero", bus.o_data_out, 0);
    bus.i_conf_dbus = 5'h1E;
    tick();
    chk("t3_status_err", bus.o_data_out, 32'h8000_0000);

    // T4: masked interrupt on bit 2, CLR colliding with a new edge
    cfg(5'h1D, 32'h004);
    bus.i_int_IP[2] = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_int_req", bus.o_int_req, 1);
    bus.i_conf_dbus = 5'h1E;
    tick();
    chk("t4_status_pending", bus.o_data_out, 32'h8000_0004);
    bus.i_int_IP[2] = 1'b0;
    tick();
    tick();
    bus.i_int_IP[2] = 1'b1;
    tick();
    cfg(5'h1C, 32'h004);
    bus.i_conf_dbus = 5'h1E;
    tick();
    chk("t4_set_wins_over_clr", bus.o_data_out, 32'h8000_0004);
    chk("t4_int_req_held", bus.o_int_req, 1);
    cfg(5'h1C, 32'h004);
    bus.i_conf_dbus = 5'h1E;
    tick();
    chk("t4_clr_alone", bus.o_data_out, 32'h8000_0000);
    chk("t4_int_req_cleared", bus.o_int_req, 0);

    // T5: unmasked-later interrupt on bit 7
    cfg(5'h1D, 32'h000);
    cfg(5'h1F, 32'd0);
    bus.i_int_IP[7] = 1'b1;
    tick();
    tick();
    tick();
    bus.i_conf_dbus = 5'h1E;
    tick();
    chk("t5_status", bus.o_data_out, 32'h0000_0080);
    chk("t5_masked_no_int", bus.o_int_req, 0);
    cfg(5'h1D, 32'h080);
    chk("t5_int_req_lag", bus.o_int_req, 0);
    tick();
    chk("t5_int_req_set", bus.o_int_req, 1);
    chk("t5_mask_readback", bus.o_data_out, 32'h0000_0080);

    // T6: enable low, then reset in the middle of a strobe
    bus.i_en_s      = 1'b0;
    bus.i_conf_dbus = 5'h02;
    bus.i_data_in   = 32'h1234_5678;
    bus.i_write     = 1'b1;
    bus.i_start     = 1'b1;
    tick();
    chk("t6_en_no_write", bus.o_writeAIP_IP, 0);
    chk("t6_en_no_start", bus.o_start_IP, 0);
    chk("t6_en_data_hold", bus.o_dataInAIP_IP, exp_data);
    chk("t6_en_data_out_hold", bus.o_data_out, 32'h0000_0080);
    bus.i_en_s      = 1'b1;
    bus.i_conf_dbus = 5'h06;
    bus.i_data_in   = 32'hCAFE_F00D;
    tick();
    chk("t6_write_slave0", bus.o_writeAIP_IP, 11'h001);
    chk("t6_start_slave0", bus.o_start_IP, 11'h001);
    rst_a = 1'b0;
    #1;
    chk("t6_rst_write", bus.o_writeAIP_IP, 0);
    chk("t6_rst_start", bus.o_start_IP, 0);
    chk("t6_rst_read", bus.o_readAIP_IP, 0);
    chk("t6_rst_data_aip", bus.o_dataInAIP_IP, 0);
    chk("t6_rst_conf_aip", bus.o_configAIP_IP, 0);
    chk("t6_rst_data_out", bus.o_data_out, 0);
    chk("t6_rst_int_req", bus.o_int_req, 0);
    bus.i_write = 1'b0;
    bus.i_start = 1'b0;
    tick();
    rst_a = 1'b1;
    tick();
    tick();
    chk("t6_post_rst_write", bus.o_writeAIP_IP, 0);
    chk("t6_post_rst_start", bus.o_start_IP, 0);
    chk("t6_post_rst_int_req", bus.o_int_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
